vote_filter: RTL and testbench

//  Parametrised N-input voter with selectable rule (minority/majority/threshold/exact) and debounce.

---
 rtl/vote_pkg.sv | 29 ++
 rtl/vote_popcount.sv | 17 +
 rtl/vote_filter.sv | 147 ++++++++++++++
 tb/tb_vote_filter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and the vote rule for vote_filter.
package vote_pkg;

  typedef enum logic [1:0] {
    MINORITY  = 2'b00,
    MAJORITY  = 2'b01,
    THRESHOLD = 2'b10,
    EXACT     = 2'b11
  } vote_mode_t;

  typedef enum logic {
    SETTLED = 1'b0,
    PENDING = 1'b1
  } vote_state_t;

  // Evaluated in 32-bit unsigned so 2*ones and thr>n never overflow.
  function automatic logic vote_rule(vote_mode_t m, int unsigned ones,
                                     int unsigned thr, int unsigned n);
    logic r;
    case (m)
      MINORITY:  r = (2 * ones < n);
      MAJORITY:  r = (2 * ones > n);
      THRESHOLD: r = (ones >= thr);
      default:   r = (ones == thr);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vote_popcount.sv
// Combinational population count of the N voted inputs.
module vote_popcount #(
  parameter  int N  = 3,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  in_bits,
  output logic [CW-1:0] ones
);

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < N; i++) begin
      ones = ones + CW'(in_bits[i]);
    end
  end

endmodule

// File: rtl/vote_filter.sv
// N-input voter with selectable rule and HOLD-sample debounce on the output.
// Optional saturating y==1 sample counter enabled by defining VOTE_STATS_EN.
module vote_filter
  import vote_pkg::*;
#(
  parameter  int   N      = 3,
  parameter  int   HOLD   = 4,
  parameter  logic Y_INIT = 1'b0,
`ifdef VOTE_STATS_EN
  parameter  int   STAT_W = 16,
`endif
  localparam int   CW     = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [N-1:0]  in_bits,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] thr,
  output logic [CW-1:0] pop,
  output logic          raw,
  output logic          y,
  output logic          y_valid,
  output logic          y_change
`ifdef VOTE_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_cnt
`endif
);

  localparam int CNT_W = $clog2(HOLD + 1);

  logic [CW-1:0]    ones;
  logic             raw_next;
  logic             s1_valid;

  vote_state_t      state, state_n;
  logic             cand, cand_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             y_n;
  logic             change_n;

  vote_popcount #(.N(N)) u_popcount (
    .in_bits (in_bits),
    .ones    (ones)
  );

  assign raw_next = vote_rule(vote_mode_t'(mode), 32'(ones), 32'(thr), 32'(N));

  // Stage 1: capture popcount and raw vote of each valid sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop      <= '0;
      raw      <= 1'b0;
      s1_valid <= 1'b0;
    end else if (clr) begin
      pop      <= '0;
      raw      <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        pop <= ones;
        raw <= raw_next;
      end
    end
  end

  // Stage 2: debounce FSM, advanced only by valid stage-1 samples.
  always_comb begin
    state_n  = state;
    cand_n   = cand;
    cnt_n    = cnt;
    y_n      = y;
    change_n = 1'b0;
    if (s1_valid) begin
      case (state)
        SETTLED: begin
          if (raw != y) begin
            if (HOLD == 1) begin
              y_n      = raw;
              change_n = 1'b1;
            end else begin
              cand_n  = raw;
              cnt_n   = CNT_W'(1);
              state_n = PENDING;
            end
          end else begin
            cnt_n = '0;
          end
        end
        default: begin
          if (raw == y) begin
            cnt_n   = '0;
            state_n = SETTLED;
          end else if (32'(cnt) + 1 == 32'(HOLD)) begin
            y_n      = cand;
            change_n = 1'b1;
            cnt_n    = '0;
            state_n  = SETTLED;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SETTLED;
      cand     <= Y_INIT;
      cnt      <= '0;
      y        <= Y_INIT;
      y_valid  <= 1'b0;
      y_change <= 1'b0;
    end else if (clr) begin
      state    <= SETTLED;
      cand     <= Y_INIT;
      cnt      <= '0;
      y        <= Y_INIT;
      y_valid  <= 1'b0;
      y_change <= 1'b0;
    end else begin
      state    <= state_n;
      cand     <= cand_n;
      cnt      <= cnt_n;
      y        <= y_n;
      y_valid  <= s1_valid;
      y_change <= change_n;
    end
  end

`ifdef VOTE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt <= '0;
    end else if (clr) begin
      stat_cnt <= '0;
    end else if (s1_valid && y_n && (stat_cnt != '1)) begin
      stat_cnt <= stat_cnt + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vote_filter.sv
// Directed bench for vote_filter: rule table plus debounce, gap, clr and stats sequences.
module tb_vote_filter;
  import vote_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clr;

  // A: N=3 HOLD=1
  logic       a_v;  logic [2:0] a_bits; logic [1:0] a_mode; logic [1:0] a_thr;
  logic [1:0] a_pop; logic a_raw, a_y, a_yv, a_yc;
  // B: N=3 HOLD=4
  logic       b_v;  logic [2:0] b_bits; logic [1:0] b_mode; logic [1:0] b_thr;
  logic [1:0] b_pop; logic b_raw, b_y, b_yv, b_yc;
  // C: N=4 HOLD=1
  logic       c_v;  logic [3:0] c_bits; logic [1:0] c_mode; logic [2:0] c_thr;
  logic [2:0] c_pop; logic c_raw, c_y, c_yv, c_yc;
`ifdef VOTE_STATS_EN
  logic [15:0] a_st, b_st, c_st;
  logic        d_v;  logic [2:0] d_bits; logic [1:0] d_pop; logic d_raw, d_y, d_yv, d_yc;
  logic [1:0]  d_st;
`endif

  vote_filter #(.N(3), .HOLD(1), .Y_INIT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(a_v), .in_bits(a_bits),
    .mode(a_mode), .thr(a_thr), .pop(a_pop), .raw(a_raw), .y(a_y),
    .y_valid(a_yv), .y_change(a_yc)
`ifdef VOTE_STATS_EN
    , .stat_cnt(a_st)
`endif
  );

  vote_filter #(.N(3), .HOLD(4), .Y_INIT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(b_v), .in_bits(b_bits),
    .mode(b_mode), .thr(b_thr), .pop(b_pop), .raw(b_raw), .y(b_y),
    .y_valid(b_yv), .y_change(b_yc)
`ifdef VOTE_STATS_EN
    , .stat_cnt(b_st)
`endif
  );

  vote_filter #(.N(4), .HOLD(1), .Y_INIT(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(c_v), .in_bits(c_bits),
    .mode(c_mode), .thr(c_thr), .pop(c_pop), .raw(c_raw), .y(c_y),
    .y_valid(c_yv), .y_change(c_yc)
`ifdef VOTE_STATS_EN
    , .stat_cnt(c_st)
`endif
  );

`ifdef VOTE_STATS_EN
  vote_filter #(.N(3), .HOLD(1), .Y_INIT(1'b0), .STAT_W(2)) dut_d (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(d_v), .in_bits(d_bits),
    .mode(2'(MAJORITY)), .thr(2'd0), .pop(d_pop), .raw(d_raw), .y(d_y),
    .y_valid(d_yv), .y_change(d_yc), .stat_cnt(d_st)
  );
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // y_change pulses of B, counted on the falling edge.
  int b_chg = 0;
  always @(negedge clk) if (b_yc === 1'b1) b_chg++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_feed(input logic [2:0] bits, input int unsigned n, input int unsigned gap);
    for (int unsigned k = 0; k < n; k++) begin
      b_v = 1'b1; b_bits = bits;
      tick();
      b_v = 1'b0;
      repeat (gap) tick();
    end
  endtask

  typedef struct {
    int unsigned sel;
    logic [3:0]  bits;
    logic [1:0]  mode;
    logic [2:0]  thr;
    int unsigned pop;
    logic        raw;
  } vec_t;

  vec_t vecs[22];
  logic prev_y[2];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int base;
    vecs[0]  = '{0, 4'b0000, 2'(MINORITY),  3'd0, 0, 1'b1};
    vecs[1]  = '{0, 4'b0001, 2'(MINORITY),  3'd0, 1, 1'b1};
    vecs[2]  = '{0, 4'b0010, 2'(MINORITY),  3'd0, 1, 1'b1};
    vecs[3]  = '{0, 4'b0011, 2'(MINORITY),  3'd0, 2, 1'b0};
    vecs[4]  = '{0, 4'b0100, 2'(MINORITY),  3'd0, 1, 1'b1};
    vecs[5]  = '{0, 4'b0101, 2'(MINORITY),  3'd0, 2, 1'b0};
    vecs[6]  = '{0, 4'b0110, 2'(MINORITY),  3'd0, 2, 1'b0};
    vecs[7]  = '{0, 4'b0111, 2'(MINORITY),  3'd0, 3, 1'b0};
    vecs[8]  = '{0, 4'b0011, 2'(MAJORITY),  3'd0, 2, 1'b1};
    vecs[9]  = '{0, 4'b0001, 2'(MAJORITY),  3'd0, 1, 1'b0};
    vecs[10] = '{0, 4'b0001, 2'(THRESHOLD), 3'd2, 1, 1'b0};
    vecs[11] = '{0, 4'b0101, 2'(THRESHOLD), 3'd2, 2, 1'b1};
    vecs[12] = '{0, 4'b0100, 2'(EXACT),     3'd1, 1, 1'b1};
    vecs[13] = '{0, 4'b0110, 2'(EXACT),     3'd1, 2, 1'b0};
    vecs[14] = '{1, 4'b1100, 2'(THRESHOLD), 3'd2, 2, 1'b1};
    vecs[15] = '{1, 4'b1100, 2'(MAJORITY),  3'd0, 2, 1'b0};
    vecs[16] = '{1, 4'b1100, 2'(MINORITY),  3'd0, 2, 1'b0};
    vecs[17] = '{1, 4'b1111, 2'(EXACT),     3'd5, 4, 1'b0};
    vecs[18] = '{1, 4'b1111, 2'(THRESHOLD), 3'd5, 4, 1'b0};
    vecs[19] = '{1, 4'b1010, 2'(EXACT),     3'd2, 2, 1'b1};
    vecs[20] = '{1, 4'b1110, 2'(MAJORITY),  3'd0, 3, 1'b1};
    vecs[21] = '{1, 4'b1000, 2'(MINORITY),  3'd0, 1, 1'b1};

    rst_n = 1'b0; clr = 1'b0;
    a_v = 1'b0; a_bits = '0; a_mode = 2'(MINORITY); a_thr = '0;
    b_v = 1'b0; b_bits = '0; b_mode = 2'(MAJORITY); b_thr = '0;
    c_v = 1'b0; c_bits = '0; c_mode = 2'(MINORITY); c_thr = '0;
`ifdef VOTE_STATS_EN
    d_v = 1'b0; d_bits = '0;
`endif
    #2;
    check("rst_pop",      32'(b_pop), 0);
    check("rst_raw",      32'(b_raw), 0);
    check("rst_y",        32'(b_y),   0);
    check("rst_y_valid",  32'(b_yv),  0);
    check("rst_y_change", 32'(b_yc),  0);
    #10 rst_n = 1'b1;
    tick();

    // Rule table on the HOLD=1 instances: y follows raw two cycles after input.
    prev_y[0] = 1'b0; prev_y[1] = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (vecs[i].sel == 0) begin
        a_v = 1'b1; a_bits = vecs[i].bits[2:0]; a_mode = vecs[i].mode; a_thr = vecs[i].thr[1:0];
      end else begin
        c_v = 1'b1; c_bits = vecs[i].bits; c_mode = vecs[i].mode; c_thr = vecs[i].thr;
      end
      tick();
      a_v = 1'b0; c_v = 1'b0;
      if (vecs[i].sel == 0) begin
        check($sformatf("v%0d_pop", i), 32'(a_pop), vecs[i].pop);
        check($sformatf("v%0d_raw", i), 32'(a_raw), 32'(vecs[i].raw));
      end else begin
        check($sformatf("v%0d_pop", i), 32'(c_pop), vecs[i].pop);
        check($sformatf("v%0d_raw", i), 32'(c_raw), 32'(vecs[i].raw));
      end
      tick();
      if (vecs[i].sel == 0) begin
        check($sformatf("v%0d_y", i),        32'(a_y),  32'(vecs[i].raw));
        check($sformatf("v%0d_y_valid", i),  32'(a_yv), 1);
        check($sformatf("v%0d_y_change", i), 32'(a_yc), 32'(vecs[i].raw != prev_y[0]));
        prev_y[0] = vecs[i].raw;
      end else begin
        check($sformatf("v%0d_y", i),        32'(c_y),  32'(vecs[i].raw));
        check($sformatf("v%0d_y_valid", i),  32'(c_yv), 1);
        check($sformatf("v%0d_y_change", i), 32'(c_yc), 32'(vecs[i].raw != prev_y[1]));
        prev_y[1] = vecs[i].raw;
      end
    end

    // Debounce: a broken streak of three never toggles.
    base = b_chg;
    b_v = 1'b1; b_bits = 3'b111;
    tick();
    b_v = 1'b0;
    tick();
    check("deb_y_valid_latency", 32'(b_yv), 1);
    b_feed(3'b111, 2, 0);
    b_feed(3'b000, 1, 0);
    repeat (3) tick();
    check("deb_broken_y",   32'(b_y), 0);
    check("deb_broken_chg", 32'(b_chg - base), 0);
    b_feed(3'b111, 4, 0);
    repeat (3) tick();
    check("deb_full_y",   32'(b_y),   1);
    check("deb_full_chg", 32'(b_chg - base), 1);
    check("deb_full_pop", 32'(b_pop), 3);
    b_feed(3'b000, 4, 0);
    repeat (3) tick();
    check("deb_back_y", 32'(b_y), 0);

    // Invalid gaps neither advance nor break the streak.
    b_feed(3'b111, 3, 2);
    repeat (2) tick();
    check("gap_3rd_y", 32'(b_y), 0);
    b_feed(3'b111, 1, 0);
    repeat (2) tick();
    check("gap_4th_y",   32'(b_y),   1);
    check("gap_4th_pop", 32'(b_pop), 3);
    b_feed(3'b000, 4, 0);
    repeat (3) tick();

    // clr mid-streak drops the streak and the in-flight sample.
    b_feed(3'b111, 3, 0);
    clr = 1'b1; b_v = 1'b1; b_bits = 3'b111;
    tick();
    clr = 1'b0; b_v = 1'b0;
    check("clr_y",       32'(b_y),   0);
    check("clr_pop",     32'(b_pop), 0);
    check("clr_raw",     32'(b_raw), 0);
    check("clr_y_valid", 32'(b_yv),  0);
    repeat (2) tick();
    check("clr_no_late_y", 32'(b_y), 0);
    b_feed(3'b111, 3, 0);
    repeat (3) tick();
    check("clr_3_after_y", 32'(b_y), 0);
    b_feed(3'b111, 1, 0);
    repeat (3) tick();
    check("clr_4_after_y", 32'(b_y), 1);

`ifdef VOTE_STATS_EN
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d_v = 1'b1; d_bits = 3'b111;
      tick();
    end
    d_v = 1'b0;
    repeat (2) tick();
    check("stat_two", 32'(d_st), 2);
    for (int k = 0; k < 4; k++) begin
      d_v = 1'b1; d_bits = 3'b111;
      tick();
    end
    d_v = 1'b0;
    repeat (2) tick();
    check("stat_sat", 32'(d_st), 3);
    check("stat_y",   32'(d_y),  1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
